ffa_req_sched: RTL
==================

FFA_REQ_SCHED -- requirements
Module: ffa_req_sched

Interface
REQ-001 Parameter DATA_W, default 8, data word width; SHALL match the flip-flop array it drives.
REQ-002 Parameter ADDR_W, default 3, address width.
REQ-003 Parameter DATA_N, default 8, entry count; SHALL equal 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 wr_valid / wr_ready  input / output  1 / 1  write request handshake.
REQ-007 wr_addr / wr_data  input  ADDR_W / DATA_W  write request payload.
REQ-008 rd_valid / rd_ready  input / output  1 / 1  read request handshake.
REQ-009 rd_addr  input  ADDR_W  read request address.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  read response handshake.
REQ-011 rsp_data / rsp_err  output  DATA_W / 1  response word; error flag set on a read of an unwritten entry.
REQ-012 wr, rd, addr, din  output  1, 1, ADDR_W, DATA_W  registered command to the flip-flop array.
REQ-013 dout / error  input  DATA_W / 1  array read data, valid the cycle after rd; array collision flag.
REQ-014 err_cnt  output  8  saturating count of cycles with error=1.

Function
REQ-015 A request SHALL be accepted on a rising edge where valid and ready are both 1.
REQ-016 At most one request SHALL be accepted per edge, so wr and rd SHALL never be 1 in the same cycle.
REQ-017 When both requests are valid and both can be accepted, the scheduler SHALL alternate: write first after reset, then the other type wins the next tie.
REQ-018 A losing request SHALL hold ready=0 for that cycle; its payload stays with the requester.
REQ-019 An accepted write SHALL drive wr=1 with addr/din set to the request for exactly the one cycle after the accepting edge.
REQ-020 An accepted write SHALL set the shadow valid bit for its address; no response SHALL be produced.
REQ-021 wr_ready SHALL be 1 whenever no read is accepted on the same edge; writes are never back-pressured by the response path.
REQ-022 The read FSM SHALL have three states: IDLE, RD_WAIT, RSP.
REQ-023 rd_ready SHALL be 1 only in IDLE.
REQ-024 Read accepted in IDLE with its shadow bit set: drive rd=1, addr=rd_addr for one cycle and move to RD_WAIT.
REQ-025 RD_WAIT lasts one cycle; on its closing edge, rsp_data SHALL capture dout, rsp_err=0, and the FSM moves to RSP.
REQ-026 Read accepted in IDLE with its shadow bit clear: no rd is issued; rsp_data=0, rsp_err=1, and the FSM moves directly to RSP.
REQ-027 In RSP, rsp_valid=1 with data and error held stable; rsp_valid&rsp_ready moves the FSM to IDLE.
REQ-028 rsp_valid SHALL be 0 in IDLE and RD_WAIT.
REQ-029 Read latency from accept edge to rsp_valid: valid entry = 2 cycles; unwritten entry = 1 cycle.
REQ-030 A write accepted on the edge before a read of the same address SHALL be visible to that read (new data, rsp_err=0).
REQ-031 When wr and rd are both 0, addr and din SHALL hold their last values.
REQ-032 err_cnt SHALL increment on each cycle error=1 and saturate at 255.

Reset
REQ-033 resetn low SHALL immediately force wr=0, rd=0, addr=0, din=0, rsp_valid=0, rsp_data=0, rsp_err=0, err_cnt=0, FSM=IDLE, all shadow bits=0, and tie priority to write.
REQ-034 Reset mid-read SHALL drop the in-flight read with no response after release.
REQ-035 wr_ready and rd_ready SHALL be 0 while resetn=0.

Verification
REQ-036 Read addr 3 after reset -> rsp_valid one cycle after accept, rsp_err=1, rsp_data=0x00, rd never asserted.
REQ-037 Write addr 5=0xA5, then read addr 5 -> wr pulse with addr=5/din=0xA5; rd pulse with addr=5; rsp_valid 2 cycles after accept, rsp_data=0xA5, rsp_err=0.
REQ-038 wr_valid and rd_valid held high together for 4 cycles (read FSM free) -> accepts alternate W,R,W,R; wr&rd never both 1; err_cnt stays 0.
REQ-039 rsp_ready=0 for 5 cycles with a response pending -> rsp_valid and rsp_data stable, rd_ready=0, writes still accepted.
REQ-040 resetn pulsed low during RD_WAIT -> all outputs per REQ-033, no rsp_valid after release, prior writes read back as rsp_err=1.
REQ-041 error forced high for 300 cycles -> err_cnt saturates at 255.

Source files
------------

// File: rtl/ffa_req_sched.sv
// ---------------------------------------------------------------------------
// ffa_req_sched
//   Schedules write and read requests onto a single-ported flip-flop array.
//   Keeps one shadow valid bit per entry so that reads of never-written
//   entries are answered locally with an error instead of touching the array.
//
// Ports
//   clk, resetn             : clock, asynchronous active-low reset
//   wr_valid/wr_ready       : write request handshake, payload wr_addr/wr_data
//   rd_valid/rd_ready       : read request handshake, payload rd_addr
//   rsp_valid/rsp_ready     : read response handshake, payload rsp_data/rsp_err
//   wr, rd, addr, din       : registered one-cycle command to the array
//   dout                    : array read data, captured at the end of RD_WAIT
//   error                   : array collision flag
//   err_cnt                 : saturating count of cycles with error high
// ---------------------------------------------------------------------------
module ffa_req_sched #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_N = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  input  logic              error,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } rd_state_t;

  rd_state_t         r_state;
  logic              r_prio_wr;   // 1: write wins the next tie
  logic [DATA_N-1:0] r_shadow;
  logic              r_wr;
  logic              r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [7:0]        r_err_cnt;

  logic w_idle;
  logic w_tie;
  logic w_rd_acc;
  logic w_wr_acc;

  // A tie exists only when the read side could actually take its request.
  // The loser of a tie sees ready low; otherwise a write is refused only when
  // a read is being accepted on the same edge, so wr and rd stay exclusive.
  assign w_idle   = (r_state == IDLE);
  assign w_tie    = wr_valid & rd_valid & w_idle;
  assign rd_ready = resetn & w_idle & ~(w_tie & r_prio_wr);
  assign w_rd_acc = rd_valid & rd_ready;
  assign wr_ready = resetn & ~w_rd_acc;
  assign w_wr_acc = wr_valid & wr_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_prio_wr   <= 1'b1;
      // NOTE: the shadow bits are reset because they define which array
      // entries hold meaningful data; the array contents themselves are not.
      r_shadow    <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Command strobes are single-cycle pulses; addr/din hold otherwise.
      r_wr <= 1'b0;
      r_rd <= 1'b0;

      // The type accepted last loses the next tie, giving strict alternation.
      if (w_wr_acc) begin
        r_wr               <= 1'b1;
        r_addr             <= wr_addr;
        r_din              <= wr_data;
        r_shadow[wr_addr]  <= 1'b1;
        r_prio_wr          <= 1'b0;
      end else if (w_rd_acc) begin
        r_prio_wr          <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_rd_acc) begin
            if (r_shadow[rd_addr]) begin
              r_rd    <= 1'b1;
              r_addr  <= rd_addr;
              r_state <= RD_WAIT;
            end else begin
              // Unwritten entry: answer locally, the array is never read.
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RSP;
            end
          end
        end
        RD_WAIT: begin
          r_rsp_data  <= dout;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= '0;
    end else if (error && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign wr        = r_wr;
  assign rd        = r_rd;
  assign addr      = r_addr;
  assign din       = r_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign err_cnt   = r_err_cnt;

endmodule
